subtrator_serial_4bits: RTL

Bit-serial subtractor: computes D = A − B − bin one bit per clock, LSB first, through a single full-subtractor cell.
It is the inverse-direction companion of the ripple adder in the ALU datapath, trading latency for area.
Operands are captured on a start pulse, and the result is presented with a one-cycle done strobe.
Flags are zero, borrow-out and signed overflow, for consumption by the ALU flag logic.

---
 rtl/subtrator_serial_4bits_if.sv | 17 +
 rtl/subtrator_serial_4bits.sv | 84 ++++++++
 2 files changed

// File: rtl/subtrator_serial_4bits_if.sv
// Request/result bundle for the bit-serial subtractor.
// The master side issues start plus operands; the slave side returns status, result and flags.
interface subtrator_serial_4bits_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         bout;
  logic         ovf;
  logic         zero;

  modport master (output start, a, b, bin, input busy, done, d, bout, ovf, zero);
  modport slave  (input start, a, b, bin, output busy, done, d, bout, ovf, zero);
endinterface

// File: rtl/subtrator_serial_4bits.sv
// Bit-serial subtractor: D = A - B - bin, one bit per clock LSB first through a single
// full-subtractor cell, with a one-cycle done strobe and zero/borrow/overflow flags.
module subtrator_serial_4bits #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst_n,
   subtrator_serial_4bits_if.slave bus
);
   localparam int CW = $clog2(N);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [N-1:0]  sa, sb, res;
   logic          brw;
   logic [CW-1:0] cnt;
   logic [N-1:0]  d_q;
   logic          bout_q, ovf_q, zero_q;

   logic          dbit, brw_nxt, last;
   logic [N-1:0]  res_nxt;

   // single full-subtractor cell on the current LSBs of the shifting operands
   assign dbit    = sa[0] ^ sb[0] ^ brw;
   assign brw_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
   assign res_nxt = {dbit, res[N-1:1]};
   assign last    = (cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         d_q    <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa    <= bus.a;
                  sb    <= bus.b;
                  brw   <= bus.bin;
                  res   <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               brw <= brw_nxt;
               res <= res_nxt;
               cnt <= cnt + CW'(1);
               // on the MSB step sa[0]/sb[0] hold the original sign bits
               if (last) begin
                  state  <= DONE;
                  d_q    <= res_nxt;
                  bout_q <= brw_nxt;
                  ovf_q  <= (sa[0] ^ sb[0]) & (dbit ^ sa[0]);
                  zero_q <= (res_nxt == '0);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.d    = d_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;

endmodule
